// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle datapath: fetch/decode/execute/memory/writeback sequencing.
// Optional macro CTRL_EXCEPTION_EN adds the EXCEPTION state for undefined Opcode/Funct.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MDRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       ALUOutWrite,
  output logic       EPCWrite,
  output logic       ALUSrcA,
  output logic [4:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [4:0] State
);

  typedef enum logic [4:0] {
    S_RESET         = 5'd0,
    S_FETCH         = 5'd1,
    S_FETCH_WAIT    = 5'd2,
    S_DECODE        = 5'd3,
    S_R_EXEC        = 5'd4,
    S_R_WB          = 5'd5,
    S_ADDI_EXEC     = 5'd6,
    S_ADDI_WB       = 5'd7,
    S_MEM_ADDR      = 5'd8,
    S_MEM_READ      = 5'd9,
    S_MEM_READ_WAIT = 5'd10,
    S_MEM_WB        = 5'd11,
    S_MEM_WRITE     = 5'd12,
    S_BRANCH        = 5'd13,
`ifdef CTRL_EXCEPTION_EN
    S_JUMP          = 5'd14,
    S_EXCEPTION     = 5'd15
`else
    S_JUMP          = 5'd14
`endif
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_write;
    logic       ir_write;
    logic       mdr_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_out_write;
    logic       epc_write;
    logic       alu_src_a;
    logic [4:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [4:0] SRCB_REGB  = 5'd0;
  localparam logic [4:0] SRCB_SEXT  = 5'd2;
  localparam logic [4:0] SRCB_FOUR  = 5'd3;
  localparam logic [4:0] SRCB_SHIFT = 5'd4;

  state_t     state_q, state_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic       is_store_q, is_store_d;
  logic [2:0] r_alu_op;
  logic       funct_ok;
  state_t     undef_target;

  // Zero gates the PC load inside the datapath; the controller never needs it.
  logic unused_zero;
  assign unused_zero = Zero;

`ifdef CTRL_EXCEPTION_EN
  assign undef_target = S_EXCEPTION;
`else
  assign undef_target = S_FETCH;
`endif

  always_comb begin
    r_alu_op = 3'b000;
    funct_ok = 1'b1;
    case (Funct)
      6'h20:   r_alu_op = ALU_ADD;
      6'h22:   r_alu_op = ALU_SUB;
      6'h24:   r_alu_op = ALU_AND;
      6'h2A:   r_alu_op = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    case (state_q)
      S_RESET:      state_d = S_FETCH;
      S_FETCH:      state_d = S_FETCH_WAIT;
      S_FETCH_WAIT: state_d = S_DECODE;
      S_DECODE: begin
        // lw/sw share MEM_ADDR; remember which one so IR is only looked at here.
        is_store_d = (Opcode == OP_SW);
        case (Opcode)
          OP_RTYPE:     state_d = funct_ok ? S_R_EXEC : undef_target;
          OP_J:         state_d = S_JUMP;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          default:      state_d = undef_target;
        endcase
      end
      S_R_EXEC:        state_d = S_R_WB;
      S_ADDI_EXEC:     state_d = S_ADDI_WB;
      S_MEM_ADDR:      state_d = is_store_q ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:      state_d = S_MEM_READ_WAIT;
      S_MEM_READ_WAIT: state_d = S_MEM_WB;
      default:         state_d = S_FETCH;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they always
  // equal the decode of the current state while staying glitch-free.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_FETCH: begin
        ctrl_d.alu_src_b = SRCB_FOUR;
        ctrl_d.alu_op    = ALU_ADD;
        ctrl_d.pc_write  = 1'b1;
      end
      S_FETCH_WAIT: ctrl_d.ir_write = 1'b1;
      S_DECODE: begin
        ctrl_d.alu_src_b     = SRCB_SHIFT;
        ctrl_d.alu_op        = ALU_ADD;
        ctrl_d.alu_out_write = 1'b1;
      end
      S_R_EXEC: begin
        ctrl_d.alu_src_a     = 1'b1;
        ctrl_d.alu_src_b     = SRCB_REGB;
        ctrl_d.alu_op        = r_alu_op;
        ctrl_d.alu_out_write = 1'b1;
      end
      S_R_WB: begin
        ctrl_d.reg_dst   = 1'b1;
        ctrl_d.reg_write = 1'b1;
      end
      S_ADDI_EXEC, S_MEM_ADDR: begin
        ctrl_d.alu_src_a     = 1'b1;
        ctrl_d.alu_src_b     = SRCB_SEXT;
        ctrl_d.alu_op        = ALU_ADD;
        ctrl_d.alu_out_write = 1'b1;
      end
      S_ADDI_WB:  ctrl_d.reg_write = 1'b1;
      S_MEM_READ: ctrl_d.ior_d = 1'b1;
      S_MEM_READ_WAIT: begin
        ctrl_d.ior_d     = 1'b1;
        ctrl_d.mdr_write = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_d.ior_d     = 1'b1;
        ctrl_d.mem_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl_d.alu_src_a     = 1'b1;
        ctrl_d.alu_src_b     = SRCB_REGB;
        ctrl_d.alu_op        = ALU_SUB;
        ctrl_d.pc_source     = 2'd1;
        ctrl_d.pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        ctrl_d.pc_source = 2'd2;
        ctrl_d.pc_write  = 1'b1;
      end
`ifdef CTRL_EXCEPTION_EN
      S_EXCEPTION: begin
        // PC has already advanced by 4; PC-4 recovers the faulting address for EPC.
        ctrl_d.alu_src_b = SRCB_FOUR;
        ctrl_d.alu_op    = ALU_SUB;
        ctrl_d.epc_write = 1'b1;
        ctrl_d.pc_source = 2'd3;
        ctrl_d.pc_write  = 1'b1;
      end
`endif
      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_RESET;
      ctrl_q     <= '0;
      is_store_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      is_store_q <= is_store_d;
    end
  end

  assign PCWrite     = ctrl_q.pc_write;
  assign PCWriteCond = ctrl_q.pc_write_cond;
  assign IorD        = ctrl_q.ior_d;
  assign MemWrite    = ctrl_q.mem_write;
  assign IRWrite     = ctrl_q.ir_write;
  assign MDRWrite    = ctrl_q.mdr_write;
  assign RegWrite    = ctrl_q.reg_write;
  assign RegDst      = ctrl_q.reg_dst;
  assign MemToReg    = ctrl_q.mem_to_reg;
  assign ALUOutWrite = ctrl_q.alu_out_write;
  assign EPCWrite    = ctrl_q.epc_write;
  assign ALUSrcA     = ctrl_q.alu_src_a;
  assign ALUSrcB     = ctrl_q.alu_src_b;
  assign ALUOp       = ctrl_q.alu_op;
  assign PCSource    = ctrl_q.pc_source;
  assign State       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instruction-level model of state sequences and per-state outputs,
// checked every cycle, plus hand-computed cycle counts, strobe counts and reset checks.
module tb_multicycle_ctrl;
  logic       clk, reset, Zero;
  logic [5:0] Opcode, Funct;
  logic       PCWrite, PCWriteCond, IorD, MemWrite, IRWrite, MDRWrite;
  logic       RegWrite, RegDst, MemToReg, ALUOutWrite, EPCWrite, ALUSrcA;
  logic [4:0] ALUSrcB, State;
  logic [2:0] ALUOp;
  logic [1:0] PCSource;

  typedef int seq_t[$];

  int   checks = 0, failures = 0;
  logic exp_valid = 1'b0;
  int   exp_state = 0;
  int   cnt_regw, cnt_memw, cnt_pcwc, cnt_epc;

`ifdef CTRL_EXCEPTION_EN
  localparam int EXC = 1;
`else
  localparam int EXC = 0;
`endif

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .MDRWrite(MDRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemToReg(MemToReg), .ALUOutWrite(ALUOutWrite), .EPCWrite(EPCWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .State(State)
  );

  wire [21:0] act_outs = {PCWrite, PCWriteCond, IorD, MemWrite, IRWrite, MDRWrite,
                          RegWrite, RegDst, MemToReg, ALUOutWrite, EPCWrite, ALUSrcA,
                          ALUSrcB, ALUOp, PCSource};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] funct_op(logic [5:0] fn);
    case (fn)
      6'h20:   return 3'b001;
      6'h22:   return 3'b010;
      6'h24:   return 3'b011;
      6'h2A:   return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  // Output table straight from the state descriptions; unlisted signals are 0.
  function automatic logic [21:0] spec_outputs(int st, logic [5:0] fn);
    logic pcw = 0, pcwc = 0, iord = 0, memw = 0, irw = 0, mdrw = 0;
    logic regw = 0, regdst = 0, m2r = 0, aluow = 0, epcw = 0, srca = 0;
    logic [4:0] srcb = 0;
    logic [2:0] aop = 0;
    logic [1:0] pcs = 0;
    case (st)
      1:     begin pcw = 1; srcb = 3; aop = 3'b001; end
      2:     irw = 1;
      3:     begin srcb = 4; aop = 3'b001; aluow = 1; end
      4:     begin srca = 1; aop = funct_op(fn); aluow = 1; end
      5:     begin regdst = 1; regw = 1; end
      6, 8:  begin srca = 1; srcb = 2; aop = 3'b001; aluow = 1; end
      7:     regw = 1;
      9:     iord = 1;
      10:    begin iord = 1; mdrw = 1; end
      11:    begin m2r = 1; regw = 1; end
      12:    begin iord = 1; memw = 1; end
      13:    begin srca = 1; aop = 3'b010; pcs = 1; pcwc = 1; end
      14:    begin pcs = 2; pcw = 1; end
      15:    begin srcb = 3; aop = 3'b010; epcw = 1; pcs = 3; pcw = 1; end
      default: ;
    endcase
    return {pcw, pcwc, iord, memw, irw, mdrw, regw, regdst, m2r, aluow, epcw, srca,
            srcb, aop, pcs};
  endfunction

  // Instruction-level model: the list of states visited from FETCH entry.
  function automatic seq_t model_seq(logic [5:0] op, logic [5:0] fn);
    seq_t q;
    q = {1, 2, 3};
    case (op)
      6'h00: begin
        if (funct_op(fn) != 3'b000) begin q.push_back(4); q.push_back(5); end
        else if (EXC == 1) q.push_back(15);
      end
      6'h02: q.push_back(14);
      6'h04: q.push_back(13);
      6'h08: begin q.push_back(6); q.push_back(7); end
      6'h23: begin q.push_back(8); q.push_back(9); q.push_back(10); q.push_back(11); end
      6'h2B: begin q.push_back(8); q.push_back(12); end
      default: if (EXC == 1) q.push_back(15);
    endcase
    return q;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int hand_cycles, input int e_regw,
                           input int e_memw, input int e_pcwc, input int e_epc);
    seq_t seq;
    int   i;
    seq = model_seq(op, fn);
    Opcode = op; Funct = fn; Zero = z;
    cnt_regw = 0; cnt_memw = 0; cnt_pcwc = 0; cnt_epc = 0;
    check({name, " model-length"}, seq.size(), hand_cycles);
    i = 0;
    while (i < 20) begin
      if (i > 0 && State == 5'd1) break;
      if (i < seq.size()) begin
        exp_valid = 1'b1;
        exp_state = seq[i];
      end else begin
        exp_valid = 1'b0;
      end
      @(posedge clk); #1;
      i++;
    end
    exp_valid = 1'b0;
    check({name, " cycles"}, i, hand_cycles);
    check({name, " RegWrite-cycles"}, cnt_regw, e_regw);
    check({name, " MemWrite-cycles"}, cnt_memw, e_memw);
    check({name, " PCWriteCond-cycles"}, cnt_pcwc, e_pcwc);
    check({name, " EPCWrite-cycles"}, cnt_epc, e_epc);
    $display("instr %-8s op=%02h fn=%02h zero=%0d cycles=%0d", name, op, fn, z, i);
  endtask

  initial begin
    reset = 1'b1; Opcode = 6'h00; Funct = 6'h00; Zero = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (exp_valid) begin
          check("state", int'(State), exp_state);
          checks++;
          if (act_outs !== spec_outputs(exp_state, Funct)) begin
            failures++;
            $display("FAIL outputs in state %0d: got %h, required %h",
                     exp_state, act_outs, spec_outputs(exp_state, Funct));
          end
          cnt_regw += int'(RegWrite);
          cnt_memw += int'(MemWrite);
          cnt_pcwc += int'(PCWriteCond);
          cnt_epc  += int'(EPCWrite);
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    check("reset State", int'(State), 0);
    check("reset outputs", int'(act_outs), 0);
    reset = 1'b0;
    check("after deassert RESET", int'(State), 0);
    @(posedge clk); #1;
    check("first FETCH State", int'(State), 1);
    check("first FETCH PCWrite", int'(PCWrite), 1);
    check("first FETCH ALUSrcB", int'(ALUSrcB), 3);

    run_instr("add",   6'h00, 6'h20, 1'b0, 5, 1, 0, 0, 0);
    run_instr("sub",   6'h00, 6'h22, 1'b0, 5, 1, 0, 0, 0);
    run_instr("and",   6'h00, 6'h24, 1'b1, 5, 1, 0, 0, 0);
    run_instr("slt",   6'h00, 6'h2A, 1'b0, 5, 1, 0, 0, 0);
    run_instr("addi",  6'h08, 6'h11, 1'b0, 5, 1, 0, 0, 0);
    run_instr("lw",    6'h23, 6'h00, 1'b0, 7, 1, 0, 0, 0);
    run_instr("sw",    6'h2B, 6'h20, 1'b0, 5, 0, 1, 0, 0);
    run_instr("beq-z1", 6'h04, 6'h00, 1'b1, 4, 0, 0, 1, 0);
    run_instr("beq-z0", 6'h04, 6'h00, 1'b0, 4, 0, 0, 1, 0);
    run_instr("j",     6'h02, 6'h00, 1'b0, 4, 0, 0, 0, 0);
    run_instr("undefop", 6'h3F, 6'h00, 1'b0, 3 + EXC, 0, 0, 0, EXC);
    run_instr("undeffn", 6'h00, 6'h3F, 1'b0, 3 + EXC, 0, 0, 0, EXC);
    run_instr("lw2",   6'h23, 6'h2A, 1'b1, 7, 1, 0, 0, 0);

    // Reset arriving in the middle of R_EXEC.
    Opcode = 6'h00; Funct = 6'h20;
    repeat (3) @(posedge clk);
    #1;
    check("mid-instr R_EXEC", int'(State), 4);
    #2;
    reset = 1'b1;
    #1;
    check("async reset State", int'(State), 0);
    check("async reset outputs", int'(act_outs), 0);
    @(posedge clk); #1;
    check("held reset State", int'(State), 0);
    reset = 1'b0;
    check("release RESET", int'(State), 0);
    @(posedge clk); #1;
    check("refetch State", int'(State), 1);
    check("refetch PCWrite", int'(PCWrite), 1);
    check("refetch ALUSrcB", int'(ALUSrcB), 3);
    $display("reset mid-instruction sequence done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
